// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCnt,
        StHi,
        StLo,
        StWr,
        StChk,
        StDone
    } state_e;

    localparam int unsigned ADDR_W_DEF      = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000000;

    // A count byte of this value requests a full-depth (2**ADDR_W word) program.
    localparam logic [7:0] CNT_BYTE_FULL_DEPTH = 8'h00;

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte idle counter: cleared on demand, counts while run is high, flags the last idle cycle.
module prog_loader_timeout #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned CNT_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires on the idle cycle whose edge brings the count to LIMIT, so the abort
    // lands on that same edge and no further byte is accepted.
    assign expired = run && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the CPU instruction memory (count byte, then 16-bit words, MSB first).
// Define LOADER_CHECKSUM_EN to require a trailing XOR check byte before done.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned TO_W        = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [15:0]       instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_wen,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned REM_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    state_e            state_q, state_d;
    logic              byte_ready_q, instr_wen_q, cpu_hold_q, done_q, err_q;
    logic [15:0]       instr_data_q;
    logic [ADDR_W-1:0] instr_addr_q;
    logic [REM_W-1:0]  remaining_q;
    logic              xfer;
    logic              to_expired;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign xfer = byte_valid && byte_ready_q;

    prog_loader_timeout #(
        .LIMIT (TIMEOUT_CYC),
        .CNT_W (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!byte_ready_q || xfer),
        .run     (byte_ready_q && !xfer),
        .expired (to_expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StCnt;
            StCnt:  if (xfer)  state_d = StHi;
            StHi:   if (xfer)  state_d = StLo;
            StLo:   if (xfer)  state_d = StWr;
            StWr: begin
                if (remaining_q == REM_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StHi;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StChk:  if (xfer) state_d = (byte_data == csum_q) ? StDone : StIdle;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (to_expired) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            byte_ready_q <= 1'b0;
            instr_wen_q  <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            instr_data_q <= '0;
            instr_addr_q <= '0;
            remaining_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            // Outputs are decoded from the next state so they align with the state register.
            byte_ready_q <= state_d inside {StCnt, StHi, StLo, StChk};
            instr_wen_q  <= (state_d == StWr);
            cpu_hold_q   <= (state_d != StIdle);
            done_q       <= (state_d == StDone);

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        err_q        <= 1'b0;
                        instr_addr_q <= '0;
                    end
                end
                StCnt: begin
                    if (xfer) begin
                        remaining_q <= (byte_data == CNT_BYTE_FULL_DEPTH) ?
                                       REM_W'(1 << ADDR_W) : REM_W'(byte_data);
`ifdef LOADER_CHECKSUM_EN
                        csum_q      <= byte_data;
`endif
                    end
                end
                StHi: begin
                    if (xfer) begin
                        instr_data_q[15:8] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q             <= csum_q ^ byte_data;
`endif
                    end
                end
                StLo: begin
                    if (xfer) begin
                        instr_data_q[7:0] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q            <= csum_q ^ byte_data;
`endif
                    end
                end
                StWr: begin
                    instr_addr_q <= instr_addr_q + ADDR_W'(1);
                    remaining_q  <= remaining_q - REM_W'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                StChk: begin
                    if (xfer && (byte_data != csum_q)) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase

            if (to_expired) err_q <= 1'b1;
        end
    end

    assign byte_ready = byte_ready_q;
    assign instr_data = instr_data_q;
    assign instr_addr = instr_addr_q;
    assign instr_wen  = instr_wen_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (define LOADER_CHECKSUM_EN to cover the check byte).
module tb_prog_loader;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned TO_W        = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic [15:0]       instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_wen;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          done_cnt = 0;

    prog_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .instr_data (instr_data),
        .instr_addr (instr_addr),
        .instr_wen  (instr_wen),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (instr_wen) begin
            wr_addr.push_back(instr_addr);
            wr_data.push_back(instr_data);
        end
        if (done) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic logic [7:0] xor_all(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_wait: byte_ready=%b after %0d cycles, required 1", byte_ready, waited);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] bytes[$], input int gap);
        start_frame();
        foreach (bytes[i]) send_byte(bytes[i], gap);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, instr_wen, cpu_hold, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: rdy/wen/hold/done/err=%b, required 00000",
                     {byte_ready, instr_wen, cpu_hold, done, err});
        end
        checks++;
        if (instr_data !== 16'h0000 || instr_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: data=%h addr=%h, required 0000/00", instr_data, instr_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: hold=%b ready=%b, required 0/0", cpu_hold, byte_ready);
        end
    endtask

    task automatic test_load();
        logic [7:0]  bytes[$];
        logic [15:0] exp_d[5] = '{16'h4810, 16'h4A12, 16'h4C14, 16'h4E16, 16'h0880};
        bit found = 0;
        bytes = '{8'h05, 8'h48, 8'h10, 8'h4A, 8'h12, 8'h4C, 8'h14, 8'h4E, 8'h16, 8'h08, 8'h80};
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(xor_all(bytes));
`endif
        clear_log();
        run_frame(bytes, 0);
        for (int i = 0; i < 20 && !found; i++) begin
            if (done) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL load_done: done=%b within 20 cycles, required 1", done);
        end else begin
            checks++;
            if (cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL load_hold_at_done: cpu_hold=%b, required 1", cpu_hold);
            end
            @(negedge clk);
            checks++;
            if (cpu_hold !== 1'b0) begin
                errors++;
                $display("FAIL load_hold_after_done: cpu_hold=%b, required 0", cpu_hold);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 5) begin
            errors++;
            $display("FAIL load_count: %0d writes, required 5", wr_addr.size());
        end
        for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL load_word%0d: got %h@%h, required %h@%h",
                         i, wr_data[i], wr_addr[i], exp_d[i], 8'(i));
            end
        end
        checks++;
        if (done_cnt !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL load_status: done pulses=%0d err=%b, required 1/0", done_cnt, err);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] bytes[$];
        bytes = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h67};
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(xor_all(bytes));
`endif
        clear_log();
        run_frame(bytes, 3);
        repeat (8) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL bp_count: %0d writes, required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_data[0] !== 16'h0123 || wr_addr[0] !== 8'h00) begin
                errors++;
                $display("FAIL bp_word0: got %h@%h, required 0123@00", wr_data[0], wr_addr[0]);
            end
            checks++;
            if (wr_data[1] !== 16'h4567 || wr_addr[1] !== 8'h01) begin
                errors++;
                $display("FAIL bp_word1: got %h@%h, required 4567@01", wr_data[1], wr_addr[1]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL bp_done: %0d done pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_full_depth();
        logic [7:0] bytes[$];
        int bad = 0;
        bytes.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            bytes.push_back(8'(i));
            bytes.push_back(~8'(i));
        end
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(xor_all(bytes));
`endif
        clear_log();
        run_frame(bytes, 0);
        repeat (8) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 256) begin
            errors++;
            $display("FAIL full_count: %0d writes, required 256", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 256; i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== {8'(i), ~8'(i)}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_words: %0d wrong writes, required 0", bad);
        end
        checks++;
        if (instr_addr !== 8'h00 || done_cnt !== 1) begin
            errors++;
            $display("FAIL full_end: addr=%h done pulses=%0d, required 00/1", instr_addr, done_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_log();
        start_frame();
        send_byte(8'h02, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        byte_valid = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 1 || wr_data[0] !== 16'hABCD || wr_addr[0] !== 8'h00) begin
            errors++;
            $display("FAIL to_write: %0d writes (first %h@%h), required 1 of ABCD@00",
                     wr_addr.size(), wr_data[0], wr_addr[0]);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL to_err: err=%b, required 1", err);
        end
        checks++;
        if (cpu_hold !== 1'b0 || byte_ready !== 1'b0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL to_idle: hold=%b ready=%b done pulses=%0d, required 0/0/0",
                     cpu_hold, byte_ready, done_cnt);
        end
        start_frame();
        checks++;
        if (err !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL to_restart: err=%b hold=%b, required 0/1", err, cpu_hold);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes[$];
        clear_log();
        start_frame();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, instr_wen, cpu_hold, done, err} !== 5'b0 ||
            instr_data !== 16'h0000 || instr_addr !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs: flags=%b data=%h addr=%h, required 0/0000/00",
                     {byte_ready, instr_wen, cpu_hold, done, err}, instr_data, instr_addr);
        end
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL midrst_nowrite: %0d writes, required 0", wr_addr.size());
        end
        bytes = '{8'h01, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(xor_all(bytes));
`endif
        clear_log();
        run_frame(bytes, 0);
        repeat (6) @(negedge clk);
        checks++;
        if (wr_addr.size() !== 1 || wr_data[0] !== 16'hBEEF || wr_addr[0] !== 8'h00 ||
            done_cnt !== 1) begin
            errors++;
            $display("FAIL midrst_reload: %0d writes (first %h@%h) done=%0d, required 1 of BEEF@00, 1",
                     wr_addr.size(), wr_data[0], wr_addr[0], done_cnt);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] bytes[$];
        bytes = '{8'h01, 8'h12, 8'h34, 8'h27};
        clear_log();
        run_frame(bytes, 0);
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt !== 1 || err !== 1'b0 || wr_data.size() !== 1 || wr_data[0] !== 16'h1234) begin
            errors++;
            $display("FAIL csum_good: done=%0d err=%b writes=%0d, required 1/0/1", done_cnt, err,
                     wr_data.size());
        end
        bytes = '{8'h01, 8'h12, 8'h34, 8'h00};
        clear_log();
        run_frame(bytes, 0);
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || err !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: done=%0d err=%b hold=%b, required 0/1/0", done_cnt, err,
                     cpu_hold);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_load();
        test_back_pressure();
        test_full_depth();
        test_timeout();
        test_reset_mid_frame();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
